neuromorphic_x1_ctrl: RTL and testbench



---
 rtl/neuromorphic_x1_pkg.sv | 31 +++
 rtl/neuromorphic_x1_cmd_fifo.sv | 44 ++++
 rtl/neuromorphic_x1_ctrl.sv | 167 ++++++++++++++++
 tb/tb_neuromorphic_x1_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuromorphic_x1_pkg.sv
// Shared types for the NEUROMORPHIC_X1 host sequencer: FSM states, the
// command entry stored in the FIFO, and bank-index sizing helpers.
package neuromorphic_x1_pkg;

    // Field widths of one queued command. These bound the controller's
    // ADDR_W/DATA_W/SEL_W; 4 bank bits cover up to 16 banks.
    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_SEL_W  = 4;
    localparam int PKG_BANK_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [PKG_BANK_W-1:0] bank;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
        logic [PKG_SEL_W-1:0]  sel;
    } cmd_t;

    // Width of a bank index; a single bank still gets one bit.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuromorphic_x1_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers. The head entry is
// visible on rdata whenever the FIFO is non-empty.
module neuromorphic_x1_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Equal indices: empty if wrap bits match, full if they differ.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    // Pointer update; push and pop are independent so both may happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/neuromorphic_x1_ctrl.sv
// Host-side sequencer for NEUROMORPHIC_X1 macro banks: queues requests,
// drives one bank's pins until func_ack or timeout, returns a response.
//
// Handshakes: a request transfers on a rising clock edge where
// req_valid && req_ready; a response transfers on an edge where
// rsp_valid && rsp_ready. req_ready never depends on the same-cycle pop.
module neuromorphic_x1_ctrl
    import neuromorphic_x1_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int SEL_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          CLKin,
    input  logic                          RSTin,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [bank_w(NUM_BANKS)-1:0]  req_bank,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_data,
    input  logic [SEL_W-1:0]              req_sel,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_err,
    output logic [NUM_BANKS-1:0]          m_en,
    output logic                          m_r_wb,
    output logic [ADDR_W-1:0]             m_ad,
    output logic [DATA_W-1:0]             m_di,
    output logic [SEL_W-1:0]              m_sel,
    input  logic [NUM_BANKS*DATA_W-1:0]   m_do,
    input  logic [NUM_BANKS-1:0]          m_ack,
    output logic                          busy,
    output state_e                        dbg_state
);

    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    cmd_t                  cmd_in;
    cmd_t                  head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [BANK_W:0]       bank_ext;
    logic [NUM_BANKS-1:0]  en_next;
    logic                  sel_ack;
    logic [DATA_W-1:0]     sel_do;
    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [PKG_BANK_W-1:0] bank_q;
    logic                  write_q;

    // Out-of-range bank numbers fold back onto an existing bank.
    assign bank_ext = {1'b0, req_bank} % (BANK_W + 1)'(NUM_BANKS);

    // Pack the host request into a FIFO entry.
    always_comb begin
        cmd_in       = '0;
        cmd_in.write = req_write;
        cmd_in.bank  = PKG_BANK_W'(bank_ext);
        cmd_in.addr  = PKG_ADDR_W'(req_addr);
        cmd_in.data  = PKG_DATA_W'(req_data);
        cmd_in.sel   = PKG_SEL_W'(req_sel);
    end

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign dbg_state = state;

    neuromorphic_x1_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk   (CLKin),
        .rst   (RSTin),
        .push  (push),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One-hot enable for the head entry and ack/DO mux for the active bank.
    always_comb begin
        en_next = '0;
        sel_ack = 1'b0;
        sel_do  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            en_next[b] = (PKG_BANK_W'(b) == head.bank);
            if (PKG_BANK_W'(b) == bank_q) begin
                sel_ack = m_ack[b];
                sel_do  = m_do[b*DATA_W +: DATA_W];
            end
        end
    end

    // Sequencer: pop into the pin registers, wait for ack or timeout, respond.
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            state     <= IDLE;
            cnt       <= '0;
            bank_q    <= '0;
            write_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            m_en      <= '0;
            m_r_wb    <= 1'b0;
            m_ad      <= '0;
            m_di      <= '0;
            m_sel     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        bank_q  <= head.bank;
                        write_q <= head.write;
                        cnt     <= '0;
                        m_en    <= en_next;
                        m_r_wb  <= !head.write;
                        m_ad    <= ADDR_W'(head.addr);
                        m_di    <= DATA_W'(head.data);
                        m_sel   <= SEL_W'(head.sel);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack in the last allowed cycle still counts as success.
                    if (sel_ack) begin
                        rsp_data  <= write_q ? '0 : sel_do;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        m_en      <= '0;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        m_en      <= '0;
                        state     <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuromorphic_x1_ctrl.sv
// Bench for neuromorphic_x1_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the sequencer.
module tb_neuromorphic_x1_ctrl;
  import neuromorphic_x1_pkg::*;

  localparam int NB = 2;
  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_bank  = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_sel   = '0;
  logic        rsp_ready = 1'b0;
  logic [63:0] m_do      = '0;
  logic [1:0]  ack_drv   = '0;
  logic [1:0]  late_ack  = '0;
  wire  [1:0]  m_ack     = ack_drv | late_ack;
  logic        req_ready, rsp_valid, rsp_err, m_r_wb, busy;
  logic [31:0] rsp_data, m_ad, m_di;
  logic [3:0]  m_sel;
  logic [1:0]  m_en;
  state_e      dbg_state;

  neuromorphic_x1_ctrl #(
    .NUM_BANKS(NB), .DATA_W(32), .ADDR_W(32), .SEL_W(4), .FIFO_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .CLKin(clk), .RSTin(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_en(m_en), .m_r_wb(m_r_wb), .m_ad(m_ad), .m_di(m_di), .m_sel(m_sel),
    .m_do(m_do), .m_ack(m_ack), .busy(busy), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction plan: request fields plus how the macro will behave
  typedef struct {
    logic        write;
    logic        bank;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] do_val;
  } tx_t;

  int          pl_delay = 0;
  logic [31:0] pl_do    = '0;
  bit          stall    = 1'b0;

  // scoreboard state
  tx_t         acc_q[$];
  logic [32:0] exp_q[$];
  int          lat_q[$];
  tx_t         cur;
  tx_t         t;
  bit          in_acc = 1'b0;
  int          k = 0;
  int          outstanding = 0;
  int          rsp_cnt = 0;
  bit          rsp_seen = 1'b0;
  logic [32:0] last_rsp = '0;
  int          last_en = 0;
  int          last_lat = 0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // model + compare + macro/consumer emulation, all on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete(); exp_q.delete(); lat_q.delete();
      in_acc = 1'b0; outstanding = 0; rsp_seen = 1'b0;
      ack_drv = '0; rsp_ready = 1'b0;
    end else begin
      chk("busy", busy, outstanding != 0);
      // request accepted at the coming edge
      if (req_valid && req_ready) begin
        t.write = req_write; t.bank = req_bank; t.addr = req_addr; t.data = req_data;
        t.sel = req_sel; t.delay = pl_delay; t.do_val = pl_do;
        acc_q.push_back(t);
        exp_q.push_back((pl_delay < TO) ? {1'b0, (req_write ? 32'h0 : pl_do)} : {1'b1, 32'h0});
        lat_q.push_back(cyc);
        outstanding++;
      end
      // macro side
      ack_drv = '0;
      if (m_en != 2'b00) begin
        if (!in_acc) begin
          if (acc_q.size() == 0) chk("unexpected_access", 1, 0);
          else begin cur = acc_q.pop_front(); in_acc = 1'b1; k = 0; end
        end
        if (in_acc) begin
          chk("m_en", m_en, 2'b01 << cur.bank);
          chk("m_r_wb", m_r_wb, !cur.write);
          chk("m_ad", m_ad, cur.addr);
          chk("m_di", m_di, cur.data);
          chk("m_sel", m_sel, cur.sel);
          m_do = {$urandom, $urandom};
          m_do[int'(cur.bank)*32 +: 32] = cur.do_val;
          if (k == cur.delay) ack_drv[cur.bank] = 1'b1;
          if ($urandom_range(0, 2) == 0) ack_drv[!cur.bank] = 1'b1;
          k++;
        end
      end else if (in_acc) begin
        chk("en_cycles", k, min_i(cur.delay + 1, TO));
        last_en = k;
        in_acc = 1'b0;
      end
      // response side
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          chk("rsp", {rsp_err, rsp_data}, exp_q[0]);
          if (!rsp_seen) begin last_lat = cyc - lat_q[0]; rsp_seen = 1'b1; end
        end
      end
      rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        last_rsp = {rsp_err, rsp_data};
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        rsp_seen = 1'b0;
        outstanding--;
        rsp_cnt++;
      end
    end
  end

  // driver tasks: call just after a rising edge; returns at the accept edge
  task automatic send(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly, input logic [31:0] dov);
    bit ok;
    ok = 1'b0;
    #1;
    req_valid = 1'b1; req_write = w; req_bank = b; req_addr = a; req_data = d; req_sel = s;
    pl_delay = dly; pl_do = dov;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk);
    end
    if (!ok) chk("send_accept_timeout", 0, 1);
  endtask

  task automatic idle_req();
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (outstanding == 0 && !in_acc && acc_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  int seen_valid;
  time t0;

  initial begin
    // reset state
    #3;
    chk("rst_m_en", m_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_m_pins", {m_r_wb, m_ad, m_di[3:0], m_sel}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk); @(negedge clk); @(posedge clk);
    #1 rst = 1'b0;

    // read on bank 1, ack two cycles after EN rises
    @(posedge clk);
    send(1'b0, 1'b1, 32'h0000_0013, 32'h0, 4'h1, 2, 32'hA5A5_5A5A);
    idle_req(); wait_idle();
    chk("t1_rsp", last_rsp, {1'b0, 32'hA5A5_5A5A});
    chk("t1_en_cycles", last_en, 3);

    // write, immediate ack, minimum latency
    @(posedge clk);
    send(1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'h3, 0, 32'hDEAD_BEEF);
    idle_req(); wait_idle();
    chk("t2_rsp", last_rsp, 33'h0);
    chk("t2_latency", last_lat, 3);
    chk("t2_en_cycles", last_en, 1);

    // timeout, then ack in the final allowed cycle
    @(posedge clk);
    send(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 20, 32'h1111_2222);
    idle_req(); wait_idle();
    chk("t3_timeout_rsp", last_rsp, {1'b1, 32'h0});
    chk("t3_timeout_en", last_en, TO);
    @(posedge clk);
    send(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'h0, TO - 1, 32'hCAFE_F00D);
    idle_req(); wait_idle();
    chk("t3_lastack_rsp", last_rsp, {1'b0, 32'hCAFE_F00D});
    chk("t3_lastack_en", last_en, TO);

    // back-pressure: 5 accepted (4 queued + 1 in flight), 6th waits
    @(posedge clk);
    stall = 1'b1;
    t0 = $time;
    for (int i = 0; i < 5; i++)
      send(i[0], i[1], 32'h1000 + i, $urandom, 4'(i), i % 3, $urandom);
    chk("bp_back_to_back", (($time - t0) / 10), 5);
    #1;
    req_write = 1'b0; req_bank = 1'b1; req_addr = 32'h1005; req_data = 32'h0;
    req_sel = 4'h5; pl_delay = 1; pl_do = 32'h0606_0606;
    @(negedge clk);
    chk("bp_req_ready_full", req_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp_still_full", req_ready, 0);
    stall = 1'b0;
    @(posedge clk);
    send(1'b0, 1'b1, 32'h1005, 32'h0, 4'h5, 1, 32'h0606_0606);
    idle_req(); wait_idle();
    chk("bp_last_rsp", last_rsp, {1'b0, 32'h0606_0606});

    // random traffic with gaps, timeouts and foreign-bank acks
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 10), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        idle_req();
        repeat ($urandom_range(1, 6)) @(posedge clk);
      end
    end
    idle_req(); wait_idle();

    // reset mid-ACCESS with two entries queued
    @(posedge clk);
    send(1'b0, 1'b0, 32'h2000, 32'h0, 4'h0, 20, 32'h7777_7777);
    send(1'b1, 1'b1, 32'h2001, 32'h5, 4'h1, 0, 32'h0);
    send(1'b0, 1'b1, 32'h2002, 32'h0, 4'h2, 0, 32'h8888_8888);
    idle_req();
    @(negedge clk);
    chk("pre_rst_in_access", m_en, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_en", m_en, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 1);
    @(negedge clk); @(posedge clk);
    #1 rst = 1'b0;
    late_ack = 2'b11;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || m_en != 2'b00) seen_valid++;
      if (i == 4) late_ack = 2'b00;
    end
    chk("late_ack_no_rsp", seen_valid, 0);
    chk("post_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
